// File: rtl/fetch_unit_if.sv
// Fetch-stage bundle: hazard/redirect controls, instruction-memory req/ack port,
// and the IF/ID register inputs. The fetch unit takes the master side.
interface fetch_unit_if;
    logic        PCWrite_en;
    logic        Redirect_en;
    logic [31:0] Redirect_PC;
    logic [31:0] IMem_Addr;
    logic        IMem_Req;
    logic        IMem_Ack;
    logic [31:0] IMem_RData;
    logic [31:0] PCPlusBy4;
    logic [31:0] InstrMem_o;
    logic        Instr_Valid;
    logic        Fetch_Bubble;

    // Memory handshake: a transfer completes in a cycle where IMem_Req=1 and
    // IMem_Ack=1; IMem_Addr stays stable while IMem_Req=1 and no Ack seen yet.
    modport master (
        input  PCWrite_en, Redirect_en, Redirect_PC, IMem_Ack, IMem_RData,
        output IMem_Addr, IMem_Req, PCPlusBy4, InstrMem_o, Instr_Valid, Fetch_Bubble
    );

    modport slave (
        output PCWrite_en, Redirect_en, Redirect_PC, IMem_Ack, IMem_RData,
        input  IMem_Addr, IMem_Req, PCPlusBy4, InstrMem_o, Instr_Valid, Fetch_Bubble
    );
endinterface

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, talks to a variable-latency instruction
// memory, and keeps an instruction returned during a stall in a one-entry buffer.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic         CLK,
    input  logic         RST,
    fetch_unit_if.master bus,
    output logic [1:0]   state_dbg
);

    typedef enum logic [1:0] {
        S_FETCH = 2'd0,
        S_HOLD  = 2'd1,
        S_KILL  = 2'd2
    } state_e;

    state_e      state;
    logic [31:0] pc;
    logic [31:0] req_addr;
    logic [31:0] buf_q;

    logic [31:0] target;
    logic [31:0] pc_next_seq;
    logic [31:0] kill_pc;
    logic        ack;
    logic        valid;

    assign ack         = bus.IMem_Ack;
    assign target      = bus.Redirect_PC & ~32'h3;
    assign pc_next_seq = pc + 32'd4;
    // In KILL a same-cycle redirect supersedes the earlier target.
    assign kill_pc     = bus.Redirect_en ? target : pc;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state    <= S_FETCH;
            pc       <= RESET_PC;
            req_addr <= RESET_PC;
            buf_q    <= 32'h0;
        end else begin
            case (state)
                S_FETCH: begin
                    if (bus.Redirect_en) begin
                        pc <= target;
                        if (ack) req_addr <= target;
                        else     state    <= S_KILL;
                    end else if (ack) begin
                        if (bus.PCWrite_en) begin
                            pc       <= pc_next_seq;
                            req_addr <= pc_next_seq;
                        end else begin
                            buf_q <= bus.IMem_RData;
                            state <= S_HOLD;
                        end
                    end
                end
                S_HOLD: begin
                    if (bus.Redirect_en) begin
                        pc       <= target;
                        req_addr <= target;
                        state    <= S_FETCH;
                    end else if (bus.PCWrite_en) begin
                        pc       <= pc_next_seq;
                        req_addr <= pc_next_seq;
                        state    <= S_FETCH;
                    end
                end
                S_KILL: begin
                    pc <= kill_pc;
                    // The stale request completes here; its data is dropped.
                    if (ack) begin
                        req_addr <= kill_pc;
                        state    <= S_FETCH;
                    end
                end
                default: state <= S_FETCH;
            endcase
        end
    end

    assign valid = ~RST & (((state == S_FETCH) & ack) | (state == S_HOLD));

    assign bus.IMem_Addr    = req_addr;
    assign bus.IMem_Req     = ~RST & (state != S_HOLD);
    assign bus.Instr_Valid  = valid;
    assign bus.Fetch_Bubble = ~valid;
    assign bus.PCPlusBy4    = pc_next_seq;
    assign bus.InstrMem_o   = (state == S_HOLD && !RST) ? buf_q :
                              (valid ? bus.IMem_RData : 32'h0);
    assign state_dbg        = state;

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed scenarios with literal expectations plus a
// randomized run checked every cycle against a transaction-level model.
module tb_fetch_unit;

    logic CLK = 1'b0;
    logic RST = 1'b0;
    logic RST_w = 1'b0;
    logic [1:0] st, st_w;

    always #5 CLK = ~CLK;

    fetch_unit_if f();
    fetch_unit_if w();

    fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
        .CLK(CLK), .RST(RST), .bus(f), .state_dbg(st)
    );

    fetch_unit #(.RESET_PC(32'hFFFF_FFFC)) dut_wrap (
        .CLK(CLK), .RST(RST_w), .bus(w), .state_dbg(st_w)
    );

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0000;
    endfunction

    // Model: the address being requested, the architectural PC, an optional
    // instruction parked because of a stall, and whether the next ack is stale.
    bit          model_on = 0;
    logic [31:0] m_pc;
    logic [31:0] m_addr;
    logic [31:0] held_q[$];
    bit          m_kill;
    bit          m_hold;
    bit          e_valid;
    logic [31:0] e_instr;
    logic [31:0] tgt;

    task automatic model_reset();
        m_pc   = 32'h0;
        m_addr = 32'h0;
        held_q.delete();
        m_kill = 0;
    endtask

    always @(negedge CLK) begin
        #1;
        if (model_on) begin
            m_hold  = (held_q.size() != 0);
            e_valid = m_hold | (!m_kill & f.IMem_Ack);
            e_instr = !e_valid ? 32'h0 : (m_hold ? held_q[0] : f.IMem_RData);
            chk("req",    {31'b0, f.IMem_Req},     {31'b0, !m_hold});
            chk("addr",   f.IMem_Addr,             m_addr);
            chk("valid",  {31'b0, f.Instr_Valid},  {31'b0, e_valid});
            chk("bubble", {31'b0, f.Fetch_Bubble}, {31'b0, !e_valid});
            chk("instr",  f.InstrMem_o,            e_instr);
            chk("pc4",    f.PCPlusBy4,             m_pc + 32'd4);

            tgt = f.Redirect_PC & ~32'h3;
            if (f.Redirect_en) begin
                m_pc = tgt;
                if (m_hold) begin
                    held_q.delete();
                    m_addr = tgt;
                end else if (m_kill) begin
                    if (f.IMem_Ack) begin m_addr = tgt; m_kill = 0; end
                end else begin
                    if (f.IMem_Ack) m_addr = tgt;
                    else            m_kill = 1;
                end
            end else if (m_hold) begin
                if (f.PCWrite_en) begin
                    held_q.delete();
                    m_pc   = m_pc + 32'd4;
                    m_addr = m_pc;
                end
            end else if (m_kill) begin
                if (f.IMem_Ack) begin m_addr = m_pc; m_kill = 0; end
            end else if (f.IMem_Ack) begin
                if (f.PCWrite_en) begin
                    m_pc   = m_pc + 32'd4;
                    m_addr = m_pc;
                end else begin
                    held_q.push_back(f.IMem_RData);
                end
            end
        end
    end

    task automatic set_in(input bit pcw, input bit redir, input logic [31:0] rpc,
                          input bit ack, input bit use_d, input logic [31:0] d);
        f.PCWrite_en  = pcw;
        f.Redirect_en = redir;
        f.Redirect_PC = rpc;
        f.IMem_Ack    = ack;
        if (use_d)    f.IMem_RData = d;
        else if (ack) f.IMem_RData = mem_word(f.IMem_Addr);
        else          f.IMem_RData = $urandom;
    endtask

    task automatic drive(input bit pcw, input bit redir, input logic [31:0] rpc,
                         input bit ack, input bit use_d, input logic [31:0] d);
        @(negedge CLK);
        set_in(pcw, redir, rpc, ack, use_d, d);
        #1;
    endtask

    initial begin
        set_in(1, 0, 32'h0, 0, 1, 32'h0);
        w.PCWrite_en  = 1'b1;
        w.Redirect_en = 1'b0;
        w.Redirect_PC = 32'h0;
        w.IMem_Ack    = 1'b1;
        w.IMem_RData  = 32'h0000_0013;
        #1;
        RST = 1'b1;
        RST_w = 1'b1;
        #2;
        chk("rst_req",    {31'b0, f.IMem_Req},     32'h0);
        chk("rst_valid",  {31'b0, f.Instr_Valid},  32'h0);
        chk("rst_instr",  f.InstrMem_o,            32'h0);
        chk("rst_bubble", {31'b0, f.Fetch_Bubble}, 32'h1);
        chk("rst_pc4",    f.PCPlusBy4,             32'h4);
        chk("rst_addr",   f.IMem_Addr,             32'h0);
        chk("wrap_rst_pc4", w.PCPlusBy4,           32'h0);
        repeat (2) @(posedge CLK);

        // Zero-wait memory: one instruction per cycle.
        @(negedge CLK);
        RST = 1'b0;
        RST_w = 1'b0;
        model_reset();
        model_on = 1;
        set_in(1, 0, 32'h0, 1, 0, 32'h0);
        #1;
        chk("wrap_addr0",  w.IMem_Addr,            32'hFFFF_FFFC);
        chk("wrap_pc4",    w.PCPlusBy4,            32'h0);
        chk("wrap_valid",  {31'b0, w.Instr_Valid}, 32'h1);
        for (int k = 0; k < 4; k++) begin
            if (k > 0) drive(1, 0, 32'h0, 1, 0, 32'h0);
            chk("seq_addr",   f.IMem_Addr,             32'(4 * k));
            chk("seq_pc4",    f.PCPlusBy4,             32'(4 * k + 4));
            chk("seq_bubble", {31'b0, f.Fetch_Bubble}, 32'h0);
            if (k == 1) chk("wrap_addr1", w.IMem_Addr, 32'h0);
        end

        // Three-cycle ack latency at 0x10.
        for (int k = 0; k < 3; k++) begin
            drive(1, 0, 32'h0, 0, 0, 32'h0);
            chk("wait_bubble", {31'b0, f.Fetch_Bubble}, 32'h1);
            chk("wait_addr",   f.IMem_Addr,             32'h10);
        end
        drive(1, 0, 32'h0, 1, 0, 32'h0);
        chk("ack_bubble", {31'b0, f.Fetch_Bubble}, 32'h0);
        chk("ack_addr",   f.IMem_Addr,             32'h10);
        drive(1, 0, 32'h0, 0, 0, 32'h0);
        chk("next_addr",  f.IMem_Addr,             32'h14);

        // Stall with an instruction in hand: held, presented, never refetched.
        drive(0, 0, 32'h0, 1, 1, 32'h8C22_0004);
        chk("stall_instr", f.InstrMem_o,            32'h8C22_0004);
        for (int k = 0; k < 3; k++) begin
            drive(0, 0, 32'h0, 1, 1, 32'hDEAD_BEEF);
            chk("hold_req",   {31'b0, f.IMem_Req},    32'h0);
            chk("hold_valid", {31'b0, f.Instr_Valid}, 32'h1);
            chk("hold_instr", f.InstrMem_o,           32'h8C22_0004);
        end
        drive(1, 0, 32'h0, 0, 0, 32'h0);
        chk("rel_instr", f.InstrMem_o, 32'h8C22_0004);
        chk("rel_pc4",   f.PCPlusBy4,  32'h18);
        drive(1, 0, 32'h0, 1, 0, 32'h0);
        chk("rel_addr",  f.IMem_Addr,  32'h18);
        drive(1, 0, 32'h0, 1, 0, 32'h0);
        chk("rel_addr2", f.IMem_Addr,  32'h1C);

        // Redirect while the request to 0x20 is outstanding.
        drive(1, 1, 32'h0000_0403, 0, 0, 32'h0);
        chk("redir_addr",  f.IMem_Addr,            32'h20);
        chk("redir_valid", {31'b0, f.Instr_Valid}, 32'h0);
        drive(1, 0, 32'h0, 0, 0, 32'h0);
        chk("kill_req",    {31'b0, f.IMem_Req},    32'h1);
        chk("kill_addr",   f.IMem_Addr,            32'h20);
        chk("kill_valid",  {31'b0, f.Instr_Valid}, 32'h0);
        drive(1, 0, 32'h0, 1, 1, 32'h1111_1111);
        chk("kill_ack_valid", {31'b0, f.Instr_Valid}, 32'h0);
        chk("kill_ack_instr", f.InstrMem_o,           32'h0);
        drive(1, 0, 32'h0, 0, 0, 32'h0);
        chk("kill_next_addr", f.IMem_Addr,            32'h400);

        // Redirect out of HOLD during a stall; the buffer is discarded.
        drive(0, 0, 32'h0, 1, 1, 32'h2222_2222);
        drive(0, 1, 32'h0000_0800, 0, 0, 32'h0);
        chk("hredir_instr", f.InstrMem_o, 32'h2222_2222);
        drive(0, 0, 32'h0, 0, 0, 32'h0);
        chk("hredir_addr",  f.IMem_Addr,            32'h800);
        chk("hredir_req",   {31'b0, f.IMem_Req},    32'h1);
        chk("hredir_valid", {31'b0, f.Instr_Valid}, 32'h0);
        chk("hredir_instr0", f.InstrMem_o,          32'h0);

        // Reset pulse while waiting for an ack.
        @(negedge CLK);
        #2;
        model_on = 0;
        RST = 1'b1;
        #1;
        chk("midrst_req",    {31'b0, f.IMem_Req},     32'h0);
        chk("midrst_bubble", {31'b0, f.Fetch_Bubble}, 32'h1);
        @(negedge CLK);
        RST = 1'b0;
        model_reset();
        model_on = 1;
        set_in(1, 0, 32'h0, 1, 0, 32'h0);
        #1;
        chk("restart_addr", f.IMem_Addr, 32'h0);

        // Randomized traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            drive($urandom_range(0, 3) != 0, $urandom_range(0, 9) == 0, $urandom,
                  $urandom_range(0, 2) != 0, 0, 32'h0);
        end

        @(negedge CLK);
        model_on = 0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
